// File: rtl/poly_arith_pkg.sv
// Shared types for the polynomial arithmetic datapath: coefficients, RAM addresses,
// and the PE writeback entry layout.
package poly_arith_pkg;

    localparam int COEFF_W     = 12;
    localparam int POLY_ADDR_W = 8;
    localparam int PE_LATENCY  = 4;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef struct packed {
        coeff_t                 u;
        coeff_t                 v;
        logic [POLY_ADDR_W-1:0] u_addr;
        logic [POLY_ADDR_W-1:0] v_addr;
    } wb_entry_t;

    typedef enum logic {
        WB_SEL_U = 1'b0,
        WB_SEL_V = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic register FIFO with explicit occupancy counter and synchronous flush.
// Latency: a pushed word is visible at rdata the cycle after the push.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty && !clr;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign push_ok = push && (!full || pop_ok) && !clr;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_wb_buffer.sv
// PE1 writeback buffer: queues (u, v) result pairs and emits them as u-beat then v-beat.
// Latency: pair pushed in cycle N presents its u beat in cycle N+1 when the buffer was empty.
// Backpressure: wr_ready_i stalls beats; afull_o warns the issuer, pushes into a full buffer set overflow_o.
module pe_wb_buffer
    import poly_arith_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = POLY_ADDR_W,
    parameter int AFULL_MARGIN = PE_LATENCY,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              valid_i,
    input  coeff_t            u_i,
    input  coeff_t            v_i,
    input  logic [ADDR_W-1:0] u_addr_i,
    input  logic [ADDR_W-1:0] v_addr_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output coeff_t            wr_data_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              overflow_o
);

    // Same layout as wb_entry_t, but following the ADDR_W parameter.
    typedef struct packed {
        coeff_t            u;
        coeff_t            v;
        logic [ADDR_W-1:0] u_addr;
        logic [ADDR_W-1:0] v_addr;
    } entry_t;

    localparam int            EW        = $bits(entry_t);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_MARGIN);

    entry_t          push_entry;
    entry_t          head;
    logic [EW-1:0]   head_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic            beat_fire;
    logic            pop;
    logic            drop;
    logic            overflow_q;
    wb_sel_e         sel_q;
    wb_sel_e         sel_d;

    assign push_entry = '{u: u_i, v: v_i, u_addr: u_addr_i, v_addr: v_addr_i};
    assign head       = entry_t'(head_dat);

    sync_fifo #(
        .DWIDTH (EW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_i),
        .push  (valid_i),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_dat),
        .count (count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_valid_o = !fifo_empty;
    assign beat_fire  = wr_valid_o && wr_ready_i;
    // The head entry retires only once its second (v) beat is accepted.
    assign pop        = beat_fire && (sel_q == WB_SEL_V);
    assign drop       = valid_i && fifo_full && !pop && !clr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= WB_SEL_U;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        sel_d     = sel_q;
        wr_addr_o = head.u_addr;
        wr_data_o = head.u;
        if (sel_q == WB_SEL_V) begin
            wr_addr_o = head.v_addr;
            wr_data_o = head.v;
        end
        if (clr_i) begin
            sel_d = WB_SEL_U;
        end else if (beat_fire) begin
            sel_d = (sel_q == WB_SEL_U) ? WB_SEL_V : WB_SEL_U;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (clr_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;
    assign empty_o    = fifo_empty;
    assign afull_o    = (count_o >= AFULL_CNT);

endmodule
